// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared defaults for the BRAM-backed FIFO controller.
// Default entry width and BRAM address width used by the interface and the RTL.
package bram_fifo_ctrl_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 11;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Stream + BRAM port bundle for bram_fifo_ctrl.
// master: the controller (drives in_ready, out_*, count, mem_* requests).
// slave:  producer/consumer/BRAM side (drives in_*, out_ready, mem_dout).
interface bram_fifo_ctrl_if
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [ADDRESS_WIDTH+1:0] count;
  logic [ADDRESS_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0]    mem_dout;
  logic                     mem_wen;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_din;

  modport master (
    input  in_valid, in_data, out_ready, mem_dout,
    output in_ready, out_valid, out_data, count,
    output mem_raddr, mem_wen, mem_waddr, mem_din
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_dout,
    input  in_ready, out_valid, out_data, count,
    input  mem_raddr, mem_wen, mem_waddr, mem_din
  );

endinterface

// File: rtl/bram_fifo_out_buf.sv
// Two-entry output buffer (out register + skid register) behind the BRAM.
// Ports: clock/reset/clear, wr_valid_i/wr_data_i (BRAM return), pop_i,
// out_valid_o/out_data_o (head), occ_o (entries held, 0..2).
module bram_fifo_out_buf
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occ_o
);

  logic                  out_v_q, out_v_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    out_v_d  = out_v_q & ~pop_i;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    // skid is older than any word arriving now
    if (!out_v_d && skid_v_q) begin
      out_v_d  = 1'b1;
      out_d    = skid_q;
      skid_v_d = 1'b0;
    end
    if (wr_valid_i) begin
      if (!out_v_d) begin
        out_v_d = 1'b1;
        out_d   = wr_data_i;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = wr_data_i;
      end
    end
    if (clear_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end

  assign out_valid_o = out_v_q;
  assign out_data_o  = out_q;
  assign occ_o       = {1'b0, out_v_q} + {1'b0, skid_v_q};

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external 1-cycle simple-dual-port BRAM.
// Ports: clock, reset (async, high), clear (sync flush), bus (master modport).
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  bram_fifo_ctrl_if.master  bus
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam int CW = ADDRESS_WIDTH + 2;
  localparam logic [PW-1:0] FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          inflight_q, inflight_d;

  logic [PW-1:0] occ;
  logic          in_ready;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    need;
  logic          out_valid;
  logic [1:0]    buf_occ;

  assign occ      = wptr_q - rptr_q;
  assign in_ready = occ != FULL;
  assign push     = bus.in_valid & in_ready;
  assign pop      = out_valid & bus.out_ready;

  // buffer slots claimed once this cycle's pop leaves
  assign need  = {1'b0, buf_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (wptr_q != rptr_q) & (need < 3'd2);

  always_comb begin
    wptr_d     = wptr_q + {{(PW-1){1'b0}}, push};
    rptr_d     = rptr_q + {{(PW-1){1'b0}}, issue};
    inflight_d = issue;
    if (clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
    end
  end

  bram_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (clear),
    .wr_valid_i  (inflight_q),
    .wr_data_i   (bus.mem_dout),
    .pop_i       (pop),
    .out_valid_o (out_valid),
    .out_data_o  (bus.out_data),
    .occ_o       (buf_occ)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = {1'b0, occ}
                       + {{(CW-1){1'b0}}, inflight_q}
                       + {{(CW-2){1'b0}}, buf_occ};
  assign bus.mem_raddr = rptr_q[ADDRESS_WIDTH-1:0];
  assign bus.mem_wen   = push;
  assign bus.mem_waddr = wptr_q[ADDRESS_WIDTH-1:0];
  assign bus.mem_din   = bus.in_data;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomized and directed bench for bram_fifo_ctrl with a read-first BRAM model.
// Scoreboard queue plus push/pop occupancy model checked every cycle.
module tb_bram_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) bus ();

  bram_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clock (clk),
    .reset (rst),
    .clear (clr),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    bus.mem_dout <= mem[bus.mem_raddr];
    if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_din;
  end

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];
  int            mdl_cnt;
  int            rx;
  bit            stall_q;
  logic [DW-1:0] stall_data;

  logic          s_ov;
  logic          s_ir;
  logic [DW-1:0] s_od;
  int            s_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] d,
                       input bit ordy, input bit cl);
    bit push;
    bit pop;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = cl;
    #1;
    s_ov  = bus.out_valid;
    s_od  = bus.out_data;
    s_ir  = bus.in_ready;
    s_cnt = int'(bus.count);
    check("count", 32'(s_cnt), 32'(mdl_cnt));
    if (mdl_cnt < DEPTH) check("in_ready", 32'(s_ir), 32'd1);
    if (stall_q) begin
      check("hold_v", 32'(s_ov), 32'd1);
      check("hold_d", 32'(s_od), 32'(stall_data));
    end
    push = iv && s_ir;
    pop  = s_ov && ordy;
    if (cl) begin
      exp_q.delete();
      mdl_cnt = 0;
      stall_q = 1'b0;
    end else begin
      if (pop) begin
        check("pop_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("data", 32'(s_od), 32'(exp_q.pop_front()));
          rx++;
        end
      end
      if (push) exp_q.push_back(d);
      mdl_cnt    = mdl_cnt + int'(push) - int'(pop);
      stall_q    = s_ov && !ordy;
      stall_data = s_od;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_cnt = 0;
    stall_q = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    #1;
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_cnt", 32'(bus.count), 32'd0);
    check("rst_ir", 32'(bus.in_ready), 32'd1);
    check("rst_wen", 32'(bus.mem_wen), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill6();
    int sent = 0;
    int cyc  = 0;
    while (sent < 6 && cyc < 50) begin
      cycle(1'b1, DW'(sent), 1'b0, 1'b0);
      if (s_ir) sent++;
      cyc++;
    end
    check("fill_sent", 32'(sent), 32'd6);
  endtask

  initial begin
    int sent;
    int cyc;
    int first;
    int rx0;
    bit iv;
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    stall_q       = 1'b0;
    mdl_cnt       = 0;
    rx            = 0;

    // 1: single word latency
    do_reset();
    cycle(1'b1, 16'hA5A5, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t1_ov", 32'(s_ov), 32'(k == 3));
      if (k == 1) check("t1_cnt1", 32'(s_cnt), 32'd1);
      if (k == 3) check("t1_data", 32'(s_od), 32'hA5A5);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_cnt0", 32'(s_cnt), 32'd0);

    // 2: full-rate stream
    do_reset();
    sent  = 0;
    cyc   = 0;
    first = -1;
    rx    = 0;
    while (rx < 100 && cyc < 300) begin
      rx0 = rx;
      cycle(sent < 100, DW'(sent), 1'b1, 1'b0);
      if (sent < 100 && s_ir) sent++;
      if (s_ov && first < 0) first = cyc;
      if (first >= 0 && rx0 < 100) check("t2_gap", 32'(s_ov), 32'd1);
      cyc++;
    end
    check("t2_first", 32'(first), 32'd3);
    check("t2_rx", 32'(rx), 32'd100);

    // 3: capacity with AW=2
    do_reset();
    fill6();
    repeat (3) begin
      cycle(1'b1, 16'h0099, 1'b0, 1'b0);
      check("t3_ir", 32'(s_ir), 32'd0);
      check("t3_cnt", 32'(s_cnt), 32'd6);
    end
    rx  = 0;
    cyc = 0;
    while (rx < 6 && cyc < 50) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      cyc++;
    end
    check("t3_rx", 32'(rx), 32'd6);

    // 4: random traffic and backpressure
    do_reset();
    sent = 0;
    cyc  = 0;
    rx   = 0;
    while (rx < 1000 && cyc < 20000) begin
      iv = (sent < 1000) && ($urandom_range(0, 3) != 0);
      cycle(iv, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (iv && s_ir) sent++;
      cyc++;
    end
    check("t4_rx", 32'(rx), 32'd1000);

    // 5: clear with push and pop in the same cycle
    do_reset();
    repeat (3) cycle(1'b1, 16'h0011, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    check("t5_cnt3", 32'(s_cnt), 32'd3);
    cycle(1'b1, 16'h0077, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t5_cnt0", 32'(s_cnt), 32'd0);
    check("t5_ov0", 32'(s_ov), 32'd0);
    repeat (6) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t5_stale", 32'(s_ov), 32'd0);
    end

    // 6: reset with a read in flight
    do_reset();
    fill6();
    cycle(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ov", 32'(bus.out_valid), 32'd0);
    check("t6_cnt", 32'(bus.count), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t6_ov_seq", 32'(s_ov), 32'(k == 3));
      if (k == 3) check("t6_data", 32'(s_od), 32'h1234);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
